// File: rtl/sensor_event_hub.sv
// sensor_event_hub: synchronises and debounces N sensor levels, turns edges into events,
// and queues them round-robin into a first-word-fall-through FIFO drained by valid/ready.
module sensor_event_hub #(
  parameter int N_CH       = 8,
  parameter int DEB_CYCLES = 1000,
  parameter int FIFO_DEPTH = 4,
  parameter bit BOTH_EDGES = 1'b0,
  parameter int CH_W       = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             sens_in,
  input  logic [N_CH-1:0]             ch_enable,
  input  logic                        ev_ready,
  input  logic                        clear_ovf,
  output logic                        ev_valid,
  output logic [CH_W-1:0]             ev_ch,
  output logic                        ev_level,
  output logic [N_CH-1:0]             stable_out,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  logic [N_CH-1:0] s1, s2, stable, chg, qual, pending, pend_level, grant_oh;
  logic [N_CH-1:0][DW-1:0] cnt;
  logic [CH_W-1:0] last_grant, grant;
  logic any_pend, push, pop;
  logic [AW-1:0] wp, rp;
  logic [CH_W:0] mem [FIFO_DEPTH];

  assign stable_out = stable;

  always_comb
    for (int i = 0; i < N_CH; i++) begin
      chg[i] = (s2[i] != stable[i]) && (cnt[i] == DMAX);
      qual[i] = chg[i] && ch_enable[i] && (BOTH_EDGES || s2[i]);
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      cnt <= '0;
    end else begin
      s1 <= sens_in;
      s2 <= s1;
      stable <= stable ^ chg;
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= (s2[i] == stable[i] || chg[i]) ? '0 : cnt[i] + DW'(1);
    end

  // Descending scan so the last hit is the nearest channel after last_grant.
  always_comb begin
    grant = '0;
    any_pend = 1'b0;
    for (int i = N_CH; i >= 1; i--)
      if (pending[(int'(last_grant) + i) % N_CH]) begin
        grant = CH_W'((int'(last_grant) + i) % N_CH);
        any_pend = 1'b1;
      end
  end

  assign push = any_pend && (fifo_count < FULL);
  assign grant_oh = push ? (N_CH'(1) << grant) : '0;
  assign ev_valid = fifo_count != '0;
  assign pop = ev_valid && ev_ready;
  assign {ev_ch, ev_level} = ev_valid ? mem[rp] : '0;

  // A new event on the channel being granted re-arms pending without counting as a loss.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      pend_level <= '0;
      overflow <= 1'b0;
      last_grant <= CH_W'(N_CH - 1);
    end else begin
      pending <= (pending & ~grant_oh) | qual;
      pend_level <= (pend_level & ~qual) | (s2 & qual);
      overflow <= (|(qual & pending & ~grant_oh)) || (overflow && !clear_ovf);
      if (push) last_grant <= grant;
    end

  always_ff @(posedge clk)
    if (push) mem[wp] <= {grant, pend_level[grant]};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
endmodule

// File: tb/tb_sensor_event_hub.sv
// tb_sensor_event_hub: directed vector table plus hand-written multi-cycle sequences
// for debounce, round-robin order, FIFO back-pressure, overflow and reset.
module tb_sensor_event_hub;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] sens = '0, sens_b = '0, en = '1;
  logic ready = 1'b0, ready_b = 1'b0, clr = 1'b0, clr_b = 1'b0;
  logic valid, lvl, ovf, valid_b, lvl_b, ovf_b;
  logic [2:0] ch, ch_b, cnt, cnt_b;
  logic [7:0] st, st_b;
  int passed = 0, total = 0;
  logic [3:0] seen[$];
  logic [2:0] ord_a [3] = '{3'd0, 3'd3, 3'd5};
  logic [2:0] ord_b [3] = '{3'd5, 3'd0, 3'd3};
  logic [3:0] exp_c [5] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100};

  typedef struct {
    logic [7:0] sens;
    logic       ready;
    logic [7:0] st;
    logic       v;
    logic [2:0] ch;
    logic       lv;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sensor_event_hub #(.N_CH(8), .DEB_CYCLES(4), .FIFO_DEPTH(4), .BOTH_EDGES(1'b0)) dut (
    .clk(clk), .rst(rst), .sens_in(sens), .ch_enable(en), .ev_ready(ready), .clear_ovf(clr),
    .ev_valid(valid), .ev_ch(ch), .ev_level(lvl), .stable_out(st), .overflow(ovf),
    .fifo_count(cnt));

  sensor_event_hub #(.N_CH(8), .DEB_CYCLES(4), .FIFO_DEPTH(4), .BOTH_EDGES(1'b1)) dut_b (
    .clk(clk), .rst(rst), .sens_in(sens_b), .ch_enable(en), .ev_ready(ready_b), .clear_ovf(clr_b),
    .ev_valid(valid_b), .ev_ch(ch_b), .ev_level(lvl_b), .stable_out(st_b), .overflow(ovf_b),
    .fifo_count(cnt_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sens = '0;
    sens_b = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic add(input logic [7:0] s, input logic r, input logic [7:0] t, input logic v,
                     input logic [2:0] c, input logic l, input logic [2:0] n);
    vec_t e;
    e.sens = s; e.ready = r; e.st = t; e.v = v; e.ch = c; e.lv = l; e.cnt = n;
    tbl.push_back(e);
  endtask

  task automatic collect(input int cycles);
    seen.delete();
    repeat (cycles) begin
      if (valid && ready) seen.push_back({lvl, ch});
      if (valid_b && ready_b) seen.push_back({lvl_b, ch_b});
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    // Rise on ch2, 3-cycle glitch on ch1, then a 4-cycle pulse on ch1 that is accepted.
    for (int i = 0; i < 5; i++) add(8'h04, 1, 8'h00, 0, 0, 0, 0);
    add(8'h04, 1, 8'h04, 0, 0, 0, 0);
    add(8'h04, 1, 8'h04, 1, 2, 1, 1);
    add(8'h04, 1, 8'h04, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(8'h06, 1, 8'h04, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(8'h04, 1, 8'h04, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(8'h06, 1, 8'h04, 0, 0, 0, 0);
    add(8'h04, 1, 8'h04, 0, 0, 0, 0);
    add(8'h04, 1, 8'h06, 0, 0, 0, 0);
    add(8'h04, 1, 8'h06, 1, 1, 1, 1);
    add(8'h04, 1, 8'h06, 0, 0, 0, 0);
    add(8'h04, 1, 8'h06, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(8'h04, 1, 8'h04, 0, 0, 0, 0);

    tick(3);
    check("reset_state", {st, valid, ch, lvl, cnt, ovf}, 17'h0);
    check("reset_state_b", {st_b, valid_b, ch_b, lvl_b, cnt_b, ovf_b}, 17'h0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      sens = tbl[i].sens;
      ready = tbl[i].ready;
      tick(1);
      check($sformatf("vec%0d", i), {st, valid, ch, lvl, cnt, ovf},
            {tbl[i].st, tbl[i].v, tbl[i].ch, tbl[i].lv, tbl[i].cnt, 1'b0});
    end

    // Round-robin from reset pointer, then with last_grant = 3.
    do_reset();
    ready = 1'b1;
    sens = 8'h29;
    tick(6);
    check("rr_stable", st, 8'h29);
    check("rr_idle", valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("rr_a%0d", i), {valid, ch, cnt}, {1'b1, ord_a[i], 3'd1});
    end
    tick(1);
    check("rr_a_empty", {valid, cnt}, 0);
    sens = 8'h00;
    tick(8);
    sens = 8'h08;
    tick(8);
    check("rr_ch3_only", {st, valid}, {8'h08, 1'b0});
    sens = 8'h00;
    tick(8);
    sens = 8'h29;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("rr_b%0d", i), {valid, ch}, {1'b1, ord_b[i]});
    end

    // Six simultaneous events into a 4-deep FIFO with the consumer stalled.
    do_reset();
    ready = 1'b0;
    sens = 8'h3F;
    tick(12);
    check("full_count", cnt, 4);
    check("full_ovf", ovf, 0);
    check("full_head", {valid, ch}, {1'b1, 3'd0});
    ready = 1'b1;
    collect(10);
    ready = 1'b0;
    check("full_delivered", seen.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("full_ev%0d", i), i < seen.size() ? seen[i] : 4'hF, {1'b1, 3'(i)});
    check("full_after", {cnt, ovf}, 0);

    // Both-edge instance: ch4 rise coalesced with its fall while stuck pending.
    do_reset();
    ready_b = 1'b0;
    sens_b = 8'h1F;
    tick(12);
    check("ovf_b_full", cnt_b, 4);
    sens_b = 8'h0F;
    tick(5);
    check("ovf_b_before", ovf_b, 0);
    tick(1);
    check("ovf_b_set", {st_b, ovf_b}, {8'h0F, 1'b1});
    ready_b = 1'b1;
    collect(8);
    ready_b = 1'b0;
    check("ovf_b_delivered", seen.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("ovf_b_ev%0d", i), i < seen.size() ? seen[i] : 4'hF, exp_c[i]);
    check("ovf_b_sticky", ovf_b, 1);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    check("ovf_b_cleared", ovf_b, 0);

    // Disabled channel, then asynchronous reset with three queued entries.
    do_reset();
    en = 8'hBF;
    sens = 8'h40;
    tick(10);
    check("dis_stable", st, 8'h40);
    check("dis_no_event", {valid, cnt}, 0);
    sens = 8'h47;
    tick(10);
    check("dis_count3", {st, cnt}, {8'h47, 3'd3});
    #2 rst = 1'b1;
    #1;
    check("async_rst", {st, valid, cnt, ovf}, 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    check("post_rst_stable", {st, valid}, {8'h47, 1'b0});
    tick(1);
    check("post_rst_event", {valid, ch, lvl, cnt}, {1'b1, 3'd0, 1'b1, 3'd1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
